// File: rtl/line_window_fetch.sv
// Sequential 9-cell line window extractor for the gobang evaluator.
// Scans four directions around a candidate cell and emits own/blocking masks per direction.
module line_window_fetch (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] pos_row,
  input  logic [3:0] pos_col,
  input  logic       player,
  output logic       rd_en,
  output logic [7:0] rd_addr,
  input  logic [1:0] rd_data,
  output logic       busy,
  output logic       line_valid,
  output logic [1:0] line_dir,
  output logic [8:0] a_line,
  output logic [8:0] b_line,
  output logic       done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_LAST = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0] r_state;
  logic [3:0] r_row;
  logic [3:0] r_col;
  logic       r_player;
  logic [1:0] r_dir;
  logic [3:0] r_k;

  logic       r_p_valid;
  logic [3:0] r_p_k;
  logic       r_p_off;
  logic [1:0] r_p_dir;

  logic [7:0] r_a_sh;
  logic [7:0] r_b_sh;
  logic       r_line_valid;
  logic [1:0] r_line_dir;
  logic [8:0] r_a_line;
  logic [8:0] r_b_line;

  logic signed [5:0] w_off;
  logic signed [5:0] w_roff;
  logic signed [5:0] w_coff;
  logic signed [5:0] w_cell_row;
  logic signed [5:0] w_cell_col;
  logic              w_offboard;
  logic [7:0]        w_addr;
  logic              w_issue;
  logic [1:0]        w_own;
  logic [1:0]        w_opp;
  logic              w_cap_a;
  logic              w_cap_b;

  assign w_off = $signed({2'b00, r_k}) - 6'sd4;

  always_comb begin
    w_roff = '0;
    w_coff = '0;
    case (r_dir)
      2'd0: w_coff = w_off;
      2'd1: w_roff = w_off;
      2'd2: begin
        w_roff = w_off;
        w_coff = w_off;
      end
      default: begin
        w_roff = w_off;
        w_coff = -w_off;
      end
    endcase
  end

  assign w_cell_row = $signed({2'b00, r_row}) + w_roff;
  assign w_cell_col = $signed({2'b00, r_col}) + w_coff;
  assign w_offboard = (w_cell_row < 6'sd0) || (w_cell_row > 6'sd14) ||
                      (w_cell_col < 6'sd0) || (w_cell_col > 6'sd14);
  // row*15 formed as row*16 - row
  assign w_addr  = {w_cell_row[3:0], 4'b0000} - {4'b0000, w_cell_row[3:0]}
                 + {4'b0000, w_cell_col[3:0]};
  assign w_issue = (r_state == S_SCAN);

  assign rd_en   = w_issue && !w_offboard;
  assign rd_addr = rd_en ? w_addr : '0;

  assign w_own = r_player ? 2'b10 : 2'b01;
  assign w_opp = r_player ? 2'b01 : 2'b10;

  // Centre is a hypothetical placement, so its RAM contents are ignored.
  always_comb begin
    w_cap_a = 1'b0;
    w_cap_b = 1'b0;
    if (r_p_k == 4'd4) begin
      w_cap_a = 1'b1;
    end else if (r_p_off) begin
      w_cap_b = 1'b1;
    end else if (rd_data == w_own) begin
      w_cap_a = 1'b1;
    end else if (rd_data == w_opp) begin
      w_cap_b = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_player     <= 1'b0;
      r_dir        <= '0;
      r_k          <= '0;
      r_p_valid    <= 1'b0;
      r_p_k        <= '0;
      r_p_off      <= 1'b0;
      r_p_dir      <= '0;
      r_a_sh       <= '0;
      r_b_sh       <= '0;
      r_line_valid <= 1'b0;
      r_line_dir   <= '0;
      r_a_line     <= '0;
      r_b_line     <= '0;
    end else begin
      r_line_valid <= 1'b0;
      r_p_valid    <= w_issue;
      r_p_k        <= r_k;
      r_p_off      <= w_offboard;
      r_p_dir      <= r_dir;

      if (r_p_valid) begin
        if (r_p_k == 4'd8) begin
          r_a_line     <= {w_cap_a, r_a_sh};
          r_b_line     <= {w_cap_b, r_b_sh};
          r_line_dir   <= r_p_dir;
          r_line_valid <= 1'b1;
        end else begin
          r_a_sh[r_p_k[2:0]] <= w_cap_a;
          r_b_sh[r_p_k[2:0]] <= w_cap_b;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (start && (pos_row <= 4'd14) && (pos_col <= 4'd14)) begin
            r_row    <= pos_row;
            r_col    <= pos_col;
            r_player <= player;
            r_dir    <= '0;
            r_k      <= '0;
            r_state  <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (r_k == 4'd8) begin
            r_k <= '0;
            if (r_dir == 2'd3) begin
              r_state <= S_LAST;
            end else begin
              r_dir <= r_dir + 2'd1;
            end
          end else begin
            r_k <= r_k + 4'd1;
          end
        end
        // Final window strobe marks the end of the pipeline drain.
        S_LAST: begin
          if (r_line_valid) begin
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign line_valid = r_line_valid;
  assign line_dir   = r_line_dir;
  assign a_line     = r_a_line;
  assign b_line     = r_b_line;

endmodule
